// File: rtl/panex_pkg.sv
// rtl/panex_pkg.sv - shared types and constants for the panex move scheduler
package panex_pkg;

  typedef enum logic [1:0] {
    PEG_L = 2'b00,
    PEG_M = 2'b01,
    PEG_R = 2'b10,
    PEG_X = 2'b11
  } peg_t;

  localparam int NUM_PEGS = 3;

  typedef enum logic [1:0] {
    RSP_OK      = 2'b00,
    RSP_NOP     = 2'b01,
    RSP_ILLEGAL = 2'b10,
    RSP_DENIED  = 2'b11
  } rsp_code_t;

  typedef enum logic [1:0] {
    ST_INIT = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/panex_peg_model.sv
// rtl/panex_peg_model.sv - shadow of the puzzle pegs, move evaluation and solved flag
module panex_peg_model
  import panex_pkg::*;
#(
  parameter int S = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic apply,
  input  peg_t fr,
  input  peg_t to,
  output logic can_move,
  output logic solving,
  output logic solved
);

  // Index 3 (invalid peg code) is a constant-zero slot so any 2-bit code indexes safely.
  logic [S-1:0] red_q  [4];
  logic [S-1:0] blue_q [4];
  logic [S-1:0] red_n  [4];
  logic [S-1:0] blue_n [4];
  logic         red_mv;
  logic         blue_mv;

  function automatic logic [S-1:0] top_bit(input logic [S-1:0] v);
    logic [S-1:0] r;
    r = '0;
    for (int i = 0; i < S; i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // Per-colour move: the top disc of a larger source vector hops to the same slot of the target.
  always_comb begin
    red_n   = red_q;
    blue_n  = blue_q;
    red_mv  = 1'b0;
    blue_mv = 1'b0;
    if (fr != PEG_X && to != PEG_X && fr != to) begin
      red_mv  = red_q[fr] > red_q[to];
      blue_mv = blue_q[fr] > blue_q[to];
      if (red_mv) begin
        red_n[fr] = red_q[fr] & ~top_bit(red_q[fr]);
        red_n[to] = red_q[to] | top_bit(red_q[fr]);
      end
      if (blue_mv) begin
        blue_n[fr] = blue_q[fr] & ~top_bit(blue_q[fr]);
        blue_n[to] = blue_q[to] | top_bit(blue_q[fr]);
      end
    end
    can_move = red_mv | blue_mv;
    solving  = (red_n[PEG_R] == '1) && (blue_n[PEG_L] == '1);
  end

  // Commit the evaluated move and latch solved on the same edge so both appear together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        red_q[i]  <= '0;
        blue_q[i] <= '0;
      end
      red_q[PEG_L]  <= '1;
      blue_q[PEG_R] <= '1;
      solved        <= 1'b0;
    end else if (apply) begin
      red_q  <= red_n;
      blue_q <= blue_n;
      if (solving) solved <= 1'b1;
    end
  end

endmodule

// File: rtl/panex_move_sched.sv
// rtl/panex_move_sched.sv - two-requester move scheduler for the panex puzzle datapath
module panex_move_sched
  import panex_pkg::*;
#(
  parameter int S         = 5,
  parameter int MAX_MOVES = 255,
  parameter int CW        = $clog2(MAX_MOVES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_valid,
  input  logic [3:0]    req_fr,
  input  logic [3:0]    req_to,
  output logic [1:0]    req_ready,
  output logic          mv_valid,
  output logic [1:0]    mv_fr,
  output logic [1:0]    mv_to,
  output logic          rsp_valid,
  output logic          rsp_id,
  output logic [1:0]    rsp_code,
  output logic [CW-1:0] move_cnt,
  output logic          solved,
  output logic          exhausted
);

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_MOVES);

  state_t    state;
  logic      rr_ptr;
  logic      accept;
  logic      gid;
  logic      apply;
  logic      can_move;
  logic      solving;
  peg_t      sel_fr;
  peg_t      sel_to;
  rsp_code_t code;

  // Round-robin grant; nothing is accepted until the first cycle after reset release.
  always_comb begin
    req_ready = 2'b00;
    if (state != ST_INIT) begin
      if (req_valid == 2'b11) req_ready = rr_ptr ? 2'b10 : 2'b01;
      else                    req_ready = req_valid;
    end
  end

  assign accept    = |req_ready;
  assign gid       = req_ready[1];
  assign sel_fr    = peg_t'(gid ? req_fr[3:2] : req_fr[1:0]);
  assign sel_to    = peg_t'(gid ? req_to[3:2] : req_to[1:0]);
  assign exhausted = (move_cnt == CNT_MAX);
  assign apply     = accept && (code == RSP_OK);

  // Response classification against the shadow as it stands this cycle.
  always_comb begin
    code = RSP_OK;
    if (state == ST_DONE)                                           code = RSP_DENIED;
    else if (sel_fr == sel_to || sel_fr == PEG_X || sel_to == PEG_X) code = RSP_ILLEGAL;
    else if (!can_move)                                             code = RSP_NOP;
  end

  panex_peg_model #(.S(S)) u_pegs (
    .clk      (clk),
    .rst      (rst),
    .apply    (apply),
    .fr       (sel_fr),
    .to       (sel_to),
    .can_move (can_move),
    .solving  (solving),
    .solved   (solved)
  );

  // FSM, response/move strobes, arbitration pointer and move counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_INIT;
      rr_ptr    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_code  <= 2'b00;
      mv_valid  <= 1'b0;
      mv_fr     <= 2'b00;
      mv_to     <= 2'b00;
      move_cnt  <= '0;
    end else begin
      rsp_valid <= accept;
      mv_valid  <= apply;
      if (accept) begin
        rsp_id   <= gid;
        rsp_code <= code;
        rr_ptr   <= ~gid;
      end
      if (apply) begin
        mv_fr <= sel_fr;
        mv_to <= sel_to;
        if (move_cnt != CNT_MAX) move_cnt <= move_cnt + CW'(1);
      end
      case (state)
        ST_INIT: state <= ST_RUN;
        ST_RUN: begin
          // Enter DONE on the edge the final move lands so the next request is already denied.
          if (solved || exhausted ||
              (apply && (solving || (move_cnt + CW'(1)) == CNT_MAX)))
            state <= ST_DONE;
        end
        default: state <= ST_DONE;
      endcase
    end
  end

endmodule

// File: doc/panex_move_sched.md
PANEX_MOVE_SCHED -- requirements
Module: panex_move_sched

Interface
REQ-001 Parameters SHALL be:
  S  5  discs per colour; shadow peg width
  MAX_MOVES  255  move budget; counter saturation value
  CW  $clog2(MAX_MOVES+1)  move_cnt width
REQ-002 Ports SHALL be (name  direction  width  meaning):
  clk  in  1  single clock, rising edge
  rst  in  1  reset, asynchronous, active-low
  req_valid  in  2  request valid, one bit per requester (0,1)
  req_fr  in  4  source peg code, bits [2i+1:2i] for requester i
  req_to  in  4  target peg code, same packing
  req_ready  out  2  grant/accept, combinational, one-hot or zero
  mv_valid  out  1  move strobe to the puzzle datapath
  mv_fr  out  2  move source peg
  mv_to  out  2  move target peg
  rsp_valid  out  1  response strobe
  rsp_id  out  1  requester the response belongs to
  rsp_code  out  2  response status
  move_cnt  out  CW  moves issued since reset
  solved  out  1  puzzle solved
  exhausted  out  1  move budget used up
REQ-003 Peg codes SHALL be 00 left, 01 middle, 10 right; 11 is invalid.

Function
REQ-004 The block SHALL hold a shadow of the datapath: six S-bit vectors (red/blue x left/mid/right).
REQ-005 A move fr->to SHALL apply independently per colour: if src > dst (unsigned), clear the highest set bit of src and set the same bit index in dst; otherwise that colour is unchanged.
REQ-006 FSM states SHALL be INIT, RUN, DONE; INIT -> RUN unconditionally one cycle after reset release; RUN -> DONE when solved or exhausted becomes 1; DONE exits only via reset.
REQ-007 In INIT req_ready SHALL be 0; in RUN and DONE one requester SHALL be granted per cycle when any req_valid is 1.
REQ-008 Arbitration SHALL be round-robin: pointer starts at requester 0, moves to the other requester after every accepted request; a lone valid requester is always granted.
REQ-009 An accepted request (req_valid & req_ready) in cycle N SHALL produce exactly one response in N+1 (rsp_valid=1, rsp_id = granted requester).
REQ-010 rsp_code SHALL be 00 OK, 01 NOP, 10 ILLEGAL, 11 DENIED, evaluated in priority order DENIED (state DONE), ILLEGAL (fr==to or any code 11), NOP (neither colour would move), else OK.
REQ-011 OK SHALL, in N+1: pulse mv_valid for one cycle with mv_fr/mv_to = request, update the shadow, increment move_cnt.
REQ-012 NOP, ILLEGAL and DENIED SHALL leave mv_valid 0, shadow and move_cnt unchanged.
REQ-013 mv_fr/mv_to SHALL hold their last values when mv_valid is 0.
REQ-014 solved SHALL be registered, 1 when shadow right_red=='1 and left_blue=='1, sticky until reset.
REQ-015 exhausted SHALL be 1 when move_cnt==MAX_MOVES; move_cnt SHALL never exceed MAX_MOVES.
REQ-016 Legality SHALL be evaluated against the shadow state including any update committed in the same edge (back-to-back requests see the previous move).

Reset
REQ-017 While rst=0: state INIT, RR pointer 0, left_red='1, right_blue='1, all other shadow vectors '0, move_cnt 0, all outputs 0.
REQ-018 Reset asserted mid-operation SHALL drop any pending response and move strobe immediately.

Structure
REQ-019 Package panex_pkg SHALL hold the peg-code typedef and constants, the rsp_code enum and the FSM state enum.
REQ-020 One sub-module panex_peg_model SHALL hold the shadow vectors, compute per-colour move-ability and the next state, and flag solved.

Verification (S=2, MAX_MOVES=2 unless stated)
REQ-021 Reset release, req0 L->M -> rsp OK id0, mv_valid one cycle 00->01, left_red=01, mid_red=10, move_cnt=1.
REQ-022 From reset, req0 M->R -> rsp NOP, mv_valid 0, move_cnt 0; req1 fr=to=01 -> rsp ILLEGAL.
REQ-023 Both req_valid high for two cycles in RUN -> grants req0 then req1, responses id0 then id1.
REQ-024 Two OK moves (L->M, M->L) -> move_cnt=2, exhausted=1, state DONE; next request -> DENIED, mv_valid 0.
REQ-025 S=1, MAX_MOVES=255: sequence L->M, R->L, M->R -> all OK, solved=1 after third move, next request DENIED.
REQ-026 rst=0 asserted in the cycle after an accept -> no rsp_valid/mv_valid, all state at reset values.
